// File: rtl/peripheral_ubus_pkg.sv
// Shared types and helpers for the byte-wide micro-bus slave.
package peripheral_ubus_pkg;

  localparam logic [1:0] Size1 = 2'b00;
  localparam logic [1:0] Size2 = 2'b01;
  localparam logic [1:0] Size4 = 2'b10;
  localparam logic [1:0] Size8 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StError
  } state_e;

  function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/peripheral_ubus_slave_mem.sv
// Byte storage: one synchronous write port, one asynchronous read port, async clear.
module peripheral_ubus_slave_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/peripheral_ubus_slave.sv
// Byte-wide micro-bus slave with wait-state insertion, range errors and
// a sticky protocol-violation flag.
module peripheral_ubus_slave
  import peripheral_ubus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        sig_clock,
  input  logic        sig_reset,
  input  logic [15:0] sig_addr,
  input  logic [1:0]  sig_size,
  input  logic        sig_read,
  input  logic        sig_write,
  input  logic        sig_start,
  input  logic        sig_bip,
  input  logic [7:0]  sig_data_in,
  output logic [7:0]  sig_data_out,
  output logic        sig_data_oe,
  output logic        sig_wait,
  output logic        sig_error,
  output logic        sig_protocol_error
);

  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DepthW  = 17'(DEPTH);
  localparam logic [1:0]  WaitMax = 2'(WAIT_STATES);

  state_e          state;
  logic [PtrW-1:0] ptr;
  logic [3:0]      beat_cnt;
  logic [3:0]      nbytes;
  logic [1:0]      wait_cnt;
  logic            is_read;
  logic            protocol_error;
  logic [7:0]      mem_rdata;

  logic        busy;
  logic        complete;
  logic        last;
  logic        mem_we;
  logic [3:0]  req_nbytes;
  logic [16:0] req_offset;
  logic        req_sel;
  logic        req_range_err;

  always_comb begin
    busy          = (state != StIdle);
    complete      = busy && (wait_cnt == WaitMax);
    last          = (beat_cnt == nbytes - 4'd1);
    mem_we        = (state == StData) && !is_read && complete;
    req_nbytes    = size_to_nbytes(sig_size);
    // 17-bit offset: an address below BASE_ADDR borrows into a huge value and fails the range test.
    req_offset    = {1'b0, sig_addr} - {1'b0, BASE_ADDR};
    req_sel       = (req_offset < DepthW) && (sig_read ^ sig_write);
    req_range_err = (req_offset + 17'(req_nbytes) - 17'd1) >= DepthW;
  end

  always_ff @(posedge sig_clock or posedge sig_reset) begin
    if (sig_reset) begin
      state          <= StIdle;
      ptr            <= '0;
      beat_cnt       <= '0;
      nbytes         <= '0;
      wait_cnt       <= '0;
      is_read        <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (sig_start && req_sel) begin
            state    <= req_range_err ? StError : StData;
            ptr      <= req_offset[PtrW-1:0];
            nbytes   <= req_nbytes;
            beat_cnt <= '0;
            wait_cnt <= '0;
            is_read  <= sig_read;
          end
        end
        StData, StError: begin
          if (sig_start) begin
            protocol_error <= 1'b1;
          end
          if (complete) begin
            wait_cnt <= '0;
            // bip must be high on every beat but the last.
            if (last == sig_bip) begin
              protocol_error <= 1'b1;
            end
            if (last) begin
              state    <= StIdle;
              beat_cnt <= '0;
              ptr      <= '0;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              ptr      <= ptr + 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    sig_wait           = busy && !complete;
    sig_error          = (state == StError);
    sig_data_oe        = busy && is_read;
    sig_data_out       = ((state == StData) && is_read) ? mem_rdata : 8'h00;
    sig_protocol_error = protocol_error;
  end

  peripheral_ubus_slave_mem #(
    .DEPTH (DEPTH),
    .AW    (PtrW)
  ) u_mem (
    .clk   (sig_clock),
    .rst   (sig_reset),
    .we    (mem_we),
    .waddr (ptr),
    .wdata (sig_data_in),
    .raddr (ptr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_peripheral_ubus_slave.sv
// Directed bench for peripheral_ubus_slave: a transfer table plus hand-written corner sequences.
module tb_peripheral_ubus_slave;

  localparam int WS = 1;

  logic        sig_clock = 1'b0;
  logic        sig_reset;
  logic [15:0] sig_addr;
  logic [1:0]  sig_size;
  logic        sig_read;
  logic        sig_write;
  logic        sig_start;
  logic        sig_bip;
  logic [7:0]  sig_data_in;
  logic [7:0]  sig_data_out;
  logic        sig_data_oe;
  logic        sig_wait;
  logic        sig_error;
  logic        sig_protocol_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sig_clock = ~sig_clock;

  peripheral_ubus_slave #(
    .BASE_ADDR   (16'h0000),
    .DEPTH       (16),
    .WAIT_STATES (WS)
  ) dut (
    .sig_clock          (sig_clock),
    .sig_reset          (sig_reset),
    .sig_addr           (sig_addr),
    .sig_size           (sig_size),
    .sig_read           (sig_read),
    .sig_write          (sig_write),
    .sig_start          (sig_start),
    .sig_bip            (sig_bip),
    .sig_data_in        (sig_data_in),
    .sig_data_out       (sig_data_out),
    .sig_data_oe        (sig_data_oe),
    .sig_wait           (sig_wait),
    .sig_error          (sig_error),
    .sig_protocol_error (sig_protocol_error)
  );

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  size;
    logic        rd;
    logic        wr;
    logic [63:0] wdata;  // byte b is sent on beat b
    logic        sel;
    logic        err;
    logic [63:0] rdata;  // byte b expected on beat b
  } vec_t;

  vec_t vecs[13];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_wait"}, sig_wait, 1'b0);
    chk1({tag, "_error"}, sig_error, 1'b0);
    chk1({tag, "_oe"}, sig_data_oe, 1'b0);
    chk8({tag, "_data"}, sig_data_out, 8'h00);
  endtask

  // Entered just after a falling edge; returns just after a falling edge with the slave idle.
  task automatic do_xfer(input logic [15:0] addr, input logic [1:0] size, input logic rd,
                         input logic wr, input logic [63:0] wdata, input logic sel,
                         input logic err, input logic [63:0] rdata, input int bad_bip,
                         input int start_beat);
    int nb;
    logic [7:0] exp_d;
    nb = 1 << size;
    sig_start = 1'b1;
    sig_addr  = addr;
    sig_size  = size;
    sig_read  = rd;
    sig_write = wr;
    sig_bip   = (nb > 1);
    @(negedge sig_clock);
    sig_start = 1'b0;
    sig_read  = 1'b0;
    sig_write = 1'b0;
    sig_addr  = 16'h0000;
    if (!sel) begin
      for (int c = 0; c < 10; c++) begin
        chk_quiet("unsel");
        @(negedge sig_clock);
      end
    end else begin
      for (int b = 0; b < nb; b++) begin
        sig_data_in = wdata[8*b +: 8];
        sig_bip     = (b != nb - 1);
        if (b == bad_bip) sig_bip = ~sig_bip;
        if (b == start_beat) begin
          sig_start = 1'b1;
          sig_addr  = 16'h0001;
          sig_read  = 1'b1;
        end
        exp_d = (rd && !err) ? rdata[8*b +: 8] : 8'h00;
        for (int c = 0; c <= WS; c++) begin
          chk1("beat_wait", sig_wait, c < WS);
          chk1("beat_error", sig_error, err);
          chk1("beat_oe", sig_data_oe, rd);
          chk8("beat_data", sig_data_out, exp_d);
          @(negedge sig_clock);
          sig_start = 1'b0;
          sig_read  = 1'b0;
        end
      end
      sig_bip = 1'b0;
      chk_quiet("post_xfer");
    end
  endtask

  initial begin
    vecs[0]  = '{16'h0003, 2'b00, 1'b0, 1'b1, 64'hA5, 1'b1, 1'b0, 64'h0};
    vecs[1]  = '{16'h0004, 2'b10, 1'b0, 1'b1, 64'h4433_2211, 1'b1, 1'b0, 64'h0};
    vecs[2]  = '{16'h0003, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'hA5};
    vecs[3]  = '{16'h0004, 2'b10, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h4433_2211};
    vecs[4]  = '{16'h000E, 2'b10, 1'b0, 1'b1, 64'hFFEE_DDCC, 1'b1, 1'b1, 64'h0};
    vecs[5]  = '{16'h000E, 2'b01, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0};
    vecs[6]  = '{16'h000E, 2'b01, 1'b0, 1'b1, 64'hC35A, 1'b1, 1'b0, 64'h0};
    vecs[7]  = '{16'h0008, 2'b11, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'hC35A_0000_0000_0000};
    vecs[8]  = '{16'h000E, 2'b10, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h0};
    vecs[9]  = '{16'h0000, 2'b00, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 64'h0};
    vecs[10] = '{16'h0000, 2'b00, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
    vecs[11] = '{16'h0010, 2'b00, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
    vecs[12] = '{16'h0100, 2'b11, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};

    sig_reset   = 1'b1;
    sig_addr    = 16'h0000;
    sig_size    = 2'b00;
    sig_read    = 1'b0;
    sig_write   = 1'b0;
    sig_start   = 1'b0;
    sig_bip     = 1'b0;
    sig_data_in = 8'h00;
    #1;
    chk_quiet("in_reset");
    chk1("in_reset_perr", sig_protocol_error, 1'b0);
    @(negedge sig_clock);
    @(negedge sig_clock);
    sig_reset = 1'b0;
    @(negedge sig_clock);
    chk_quiet("after_reset");

    for (int i = 0; i < 13; i++) begin
      do_xfer(vecs[i].addr, vecs[i].size, vecs[i].rd, vecs[i].wr, vecs[i].wdata,
              vecs[i].sel, vecs[i].err, vecs[i].rdata, -1, -1);
    end
    chk1("clean_perr", sig_protocol_error, 1'b0);

    // bip dropped on the first of four beats: flagged, length still set by the beat count.
    do_xfer(16'h0000, 2'b10, 1'b0, 1'b1, 64'hEFBE_ADDE, 1'b1, 1'b0, 64'h0, 0, -1);
    chk1("bip_early_perr", sig_protocol_error, 1'b1);

    // Asynchronous reset away from a clock edge clears the sticky flag.
    #2 sig_reset = 1'b1;
    #1 chk1("reset_clears_perr", sig_protocol_error, 1'b0);
    @(negedge sig_clock);
    sig_reset = 1'b0;
    @(negedge sig_clock);

    // Start during a read is ignored for decoding but flagged.
    do_xfer(16'h0004, 2'b10, 1'b0, 1'b1, 64'h4433_2211, 1'b1, 1'b0, 64'h0, -1, -1);
    chk1("pre_start_perr", sig_protocol_error, 1'b0);
    do_xfer(16'h0004, 2'b01, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h2211, -1, 0);
    chk1("start_busy_perr", sig_protocol_error, 1'b1);

    // Reset during beat 2 of an 8-byte write.
    sig_start = 1'b1;
    sig_addr  = 16'h0000;
    sig_size  = 2'b11;
    sig_write = 1'b1;
    sig_bip   = 1'b1;
    @(negedge sig_clock);
    sig_start   = 1'b0;
    sig_write   = 1'b0;
    sig_data_in = 8'h01;
    @(negedge sig_clock);
    @(negedge sig_clock);
    sig_data_in = 8'h02;
    chk1("mid_write_wait", sig_wait, 1'b1);
    #2 sig_reset = 1'b1;
    #1;
    chk_quiet("mid_reset");
    chk1("mid_reset_perr", sig_protocol_error, 1'b0);
    @(negedge sig_clock);
    sig_reset = 1'b0;
    sig_bip   = 1'b0;
    @(negedge sig_clock);
    do_xfer(16'h0000, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h00, -1, -1);
    do_xfer(16'h0004, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h00, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
